// File: rtl/mux_nto1_arb.sv
// mux_nto1_arb: N-channel valid/ready mux, selected by explicit index or round-robin, registered output.
// Latency: a word accepted at edge k is on out_data/out_ch from edge k to k+1.
// Backpressure: output holds while out_valid && !out_ready, and every in_ready is low until it drains.
module mux_nto1_arb #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    parameter int SW   = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH*DW-1:0] in_data,
    input  logic [N_CH-1:0]    in_valid,
    output logic [N_CH-1:0]    in_ready,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    output logic [DW-1:0]      out_data,
    output logic [SW-1:0]      out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    logic            load_en;
    logic            xfer;
    logic            found;
    logic [N_CH-1:0] grant;
    logic [SW-1:0]   ptr;
    logic [SW-1:0]   gidx;
    logic [DW-1:0]   gdata;
    int              idx;

    assign load_en = !out_valid || out_ready;

    // Grant is a pure function of requests and pointer; readiness gating is applied afterwards.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        if (!mode) begin
            // An out-of-range sel matches no channel, so nothing is granted.
            for (int c = 0; c < N_CH; c++) begin
                if (int'(sel) == c && in_valid[c]) begin
                    grant[c] = 1'b1;
                    gidx     = SW'(c);
                end
            end
        end else begin
            for (int i = 1; i <= N_CH; i++) begin
                idx = (int'(ptr) + i) % N_CH;
                if (!found && in_valid[SW'(idx)]) begin
                    found              = 1'b1;
                    grant[SW'(idx)]    = 1'b1;
                    gidx               = SW'(idx);
                end
            end
        end
    end

    always_comb begin
        gdata = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (grant[c]) begin
                gdata = in_data[c*DW +: DW];
            end
        end
    end

    assign in_ready = (rst_n && load_en) ? grant : '0;
    assign xfer     = |in_ready;

    // ptr follows every real transfer, in either mode, so arbitration resumes after the last winner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SW'(N_CH - 1);
        end else if (load_en) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= gdata;
                out_ch   <= gidx;
                ptr      <= gidx;
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_arb.sv
// Bench for mux_nto1_arb: a 4x1-bit instance for the fixed-select sweep, and a 6x8-bit
// instance for directed arbitration/backpressure/reset vectors plus a randomized model check.
module tb_mux_nto1_arb;

    localparam int NB = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4-channel, 1-bit instance
    logic [3:0] a_in_data, a_in_valid, a_in_ready;
    logic       a_mode, a_out_valid, a_out_ready;
    logic [1:0] a_sel, a_out_ch;
    logic [0:0] a_out_data;

    // 6-channel, 8-bit instance (non-power-of-two: sel 6,7 are out of range)
    logic [NB*8-1:0] b_in_data;
    logic [NB-1:0]   b_in_valid, b_in_ready;
    logic            b_mode, b_out_valid, b_out_ready;
    logic [2:0]      b_sel, b_out_ch;
    logic [7:0]      b_out_data;

    mux_nto1_arb #(.N_CH(4), .DW(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .mode(a_mode), .sel(a_sel),
        .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    mux_nto1_arb #(.N_CH(NB), .DW(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mode(b_mode), .sel(b_sel),
        .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       mode;
        logic [2:0] sel;
        logic [5:0] vld;
        logic       ordy;
        logic [5:0] rdy;
        logic       ov;
        int         ch;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic rst, input logic mode, input logic [2:0] sel, input logic [5:0] vld,
                       input logic ordy, input logic [5:0] rdy, input logic ov, input int ch);
        vec_t v;
        v.rst = rst; v.mode = mode; v.sel = sel; v.vld = vld;
        v.ordy = ordy; v.rdy = rdy; v.ov = ov; v.ch = ch;
        tbl.push_back(v);
    endtask

    // Reference model: output register contents plus the channel that last won.
    logic       m_ov;
    logic [7:0] m_od;
    int         m_oc;
    int         m_ptr;

    // Winner is the requester closest after the last winner in circular order.
    function automatic int model_grant();
        int best, bestd, d;
        best  = -1;
        bestd = NB + 1;
        if (!rst_n) return -1;
        if (m_ov && !b_out_ready) return -1;
        for (int c = 0; c < NB; c++) begin
            if (b_in_valid[c]) begin
                if (!b_mode) begin
                    if (c == int'(b_sel)) best = c;
                end else begin
                    d = (c - m_ptr - 1 + 2 * NB) % NB;
                    if (d < bestd) begin
                        bestd = d;
                        best  = c;
                    end
                end
            end
        end
        return best;
    endfunction

    task automatic step(input int k);
        int         g;
        logic [5:0] exp_rdy;
        logic       was_rst;
        #1;
        g       = model_grant();
        was_rst = !rst_n;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("rnd.in_ready", k, 32'(b_in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (was_rst) begin
            m_ov = 1'b0; m_od = 8'h00; m_oc = 0; m_ptr = NB - 1;
        end else if (g >= 0) begin
            m_ov = 1'b1; m_od = b_in_data[g*8 +: 8]; m_oc = g; m_ptr = g;
        end else if (b_out_ready) begin
            m_ov = 1'b0;
        end
        #1;
        chk("rnd.out_valid", k, 32'(b_out_valid), 32'(m_ov));
        if (m_ov || was_rst) begin
            chk("rnd.out_data", k, 32'(b_out_data), 32'(m_od));
            chk("rnd.out_ch", k, 32'(b_out_ch), 32'(m_oc));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] a_exp_data;
        a_exp_data = 4'b1010;

        // Directed vectors for the 6-channel instance; data on channel c is 8'hA0 + c.
        //  rst mode sel vld    ordy rdy    ov ch
        row(0, 1, 0, 6'h3F, 1, 6'h00, 0, 0);
        row(1, 1, 0, 6'h0F, 1, 6'h01, 1, 0);   // fairness from reset: 0,1,2,3,0,1
        row(1, 1, 0, 6'h0F, 1, 6'h02, 1, 1);
        row(1, 1, 0, 6'h0F, 1, 6'h04, 1, 2);
        row(1, 1, 0, 6'h0F, 1, 6'h08, 1, 3);
        row(1, 1, 0, 6'h0F, 1, 6'h01, 1, 0);
        row(1, 1, 0, 6'h0F, 1, 6'h02, 1, 1);
        row(1, 1, 0, 6'h0A, 1, 6'h08, 1, 3);   // sparse ch1/ch3
        row(1, 1, 0, 6'h0A, 1, 6'h02, 1, 1);
        row(1, 1, 0, 6'h0A, 1, 6'h08, 1, 3);
        row(1, 1, 0, 6'h0A, 1, 6'h02, 1, 1);
        row(1, 1, 0, 6'h0F, 1, 6'h04, 1, 2);   // load A2/ch2, then stall 3 cycles
        row(1, 1, 0, 6'h0F, 0, 6'h00, 1, 2);
        row(1, 1, 0, 6'h0F, 0, 6'h00, 1, 2);
        row(1, 1, 0, 6'h0F, 0, 6'h00, 1, 2);
        row(1, 1, 0, 6'h0F, 1, 6'h08, 1, 3);   // release: ch3 granted same cycle
        row(1, 1, 0, 6'h0F, 1, 6'h01, 1, 0);
        row(1, 1, 0, 6'h0F, 1, 6'h02, 1, 1);
        row(1, 0, 3, 6'h0F, 1, 6'h08, 1, 3);   // fixed sel=3
        row(1, 1, 0, 6'h0F, 1, 6'h01, 1, 0);   // back to RR, ptr=3 -> ch0
        row(1, 0, 5, 6'h3F, 1, 6'h20, 1, 5);
        row(1, 0, 6, 6'h3F, 1, 6'h00, 0, 0);   // out-of-range sel, output drains
        row(1, 0, 7, 6'h3F, 1, 6'h00, 0, 0);
        row(1, 1, 0, 6'h3F, 1, 6'h01, 1, 0);   // ptr kept at 5 -> ch0
        row(1, 1, 0, 6'h30, 1, 6'h10, 1, 4);
        row(1, 1, 0, 6'h21, 1, 6'h20, 1, 5);
        row(1, 1, 0, 6'h21, 1, 6'h01, 1, 0);   // wrap 5 -> 0
        row(1, 0, 2, 6'h3B, 1, 6'h00, 0, 0);   // selected channel not requesting
        row(1, 1, 0, 6'h0F, 0, 6'h02, 1, 1);   // empty output loads even with out_ready low
        row(1, 1, 0, 6'h0F, 0, 6'h00, 1, 1);
        row(0, 1, 0, 6'h0F, 0, 6'h00, 0, 0);   // reset discards held word
        row(0, 1, 0, 6'h0F, 1, 6'h00, 0, 0);
        row(1, 1, 0, 6'h3F, 1, 6'h01, 1, 0);   // first grant after reset is ch0

        rst_n       = 1'b0;
        a_in_data   = 4'b1010;
        a_in_valid  = 4'hF;
        a_mode      = 1'b0;
        a_sel       = 2'd0;
        a_out_ready = 1'b1;
        for (int c = 0; c < NB; c++) b_in_data[c*8 +: 8] = 8'(8'hA0 + c);
        b_in_valid  = 6'h3F;
        b_mode      = 1'b1;
        b_sel       = 3'd0;
        b_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.a_out_valid", 0, 32'(a_out_valid), 32'd0);
        chk("rst.a_out_data", 0, 32'(a_out_data), 32'd0);
        chk("rst.a_out_ch", 0, 32'(a_out_ch), 32'd0);
        chk("rst.a_in_ready", 0, 32'(a_in_ready), 32'd0);
        chk("rst.b_out_valid", 0, 32'(b_out_valid), 32'd0);
        chk("rst.b_out_data", 0, 32'(b_out_data), 32'd0);
        chk("rst.b_out_ch", 0, 32'(b_out_ch), 32'd0);
        chk("rst.b_in_ready", 0, 32'(b_in_ready), 32'd0);

        // Fixed-select sweep on the 1-bit instance.
        b_in_valid = '0;
        rst_n      = 1'b1;
        for (int s = 0; s < 4; s++) begin
            a_sel = 2'(s);
            #1;
            chk("fix.in_ready", s, 32'(a_in_ready), 32'(1) << s);
            @(posedge clk);
            #1;
            chk("fix.out_valid", s, 32'(a_out_valid), 32'd1);
            chk("fix.out_data", s, 32'(a_out_data), 32'(a_exp_data[s]));
            chk("fix.out_ch", s, 32'(a_out_ch), 32'(s));
        end

        // Directed table on the 6-channel instance.
        for (int i = 0; i < tbl.size(); i++) begin
            rst_n       = tbl[i].rst;
            b_mode      = tbl[i].mode;
            b_sel       = tbl[i].sel;
            b_in_valid  = tbl[i].vld;
            b_out_ready = tbl[i].ordy;
            #1;
            chk("tbl.in_ready", i, 32'(b_in_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk("tbl.out_valid", i, 32'(b_out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov || !tbl[i].rst) begin
                chk("tbl.out_ch", i, 32'(b_out_ch), 32'(tbl[i].ch));
                chk("tbl.out_data", i, 32'(b_out_data), tbl[i].rst ? 32'(8'hA0 + tbl[i].ch) : 32'd0);
            end
        end

        // Randomized run against the reference model, starting from a reset cycle.
        rst_n = 1'b0;
        step(0);
        for (int k = 1; k <= 600; k++) begin
            rst_n       = ($urandom_range(0, 59) != 0);
            b_mode      = ($urandom_range(0, 3) != 0);
            b_sel       = 3'($urandom_range(0, 7));
            b_in_valid  = 6'($urandom);
            b_out_ready = ($urandom_range(0, 9) < 7);
            for (int c = 0; c < NB; c++) b_in_data[c*8 +: 8] = 8'($urandom);
            step(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_nto1_arb.md
# mux_nto1_arb

Parametrised N-channel multiplexer with per-channel valid/ready handshakes and a registered output stage. It is the sequential successor to the plain 4:1 bit-select mux. Each channel carries a DW-bit word, and the output is chosen either by an explicit select (fixed mode) or by a round-robin arbiter (arbitrated mode). It sits between multiple producers and a single downstream consumer that may apply backpressure.

## Interface
Parameters:
- N_CH, 4, number of input channels (≥ 2)
- DW, 8, data width per channel
- SW, $clog2(N_CH), select/channel-index width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  synchronous, active-low reset (sampled on rising clk)
- in_data  input  N_CH*DW  channel c occupies bits [c*DW +: DW]
- in_valid  input  N_CH  per-channel request
- in_ready  output  N_CH  per-channel accept (combinational)
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SW  channel index used in fixed mode
- out_data  output  DW  registered selected word
- out_ch  output  SW  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_ch hold a word
- out_ready  input  1  downstream accept

## Operation
- One output register (data, ch, valid). `load_en = !out_valid || out_ready`.
- A transfer on channel c occurs in a cycle where in_valid[c] && in_ready[c]. The output register captures in_data[c] and c at the clock edge, and out_valid goes to 1.
- in_ready[c] = load_en && grant[c]. At most one grant bit is set per cycle.
- Fixed mode (mode = 0):
  - grant[sel] = in_valid[sel]. All other channels are not ready.
  - sel ≥ N_CH: no grant, no transfer.
- Round-robin mode (mode = 1):
  - Search in_valid starting at index (ptr+1) mod N_CH, wrapping upward. The first set bit is granted.
  - ptr updates to the granted index only on an actual transfer.
  - ptr holds if there is no transfer, including when a request is present but load_en = 0.
- ptr is retained across mode changes. A mode change takes effect in the same cycle; no state is flushed.
- Drain without refill: if out_valid && out_ready and no grant, out_valid clears to 0 at the edge.
- Backpressure: while out_valid && !out_ready, out_data, out_ch and out_valid hold stable. All in_ready are 0.
- Transfers are lossless: each accepted word appears exactly once on the output, in acceptance order.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - out_valid = 0, out_data = 0, out_ch = 0.
  - ptr = N_CH-1, so channel 0 has first priority after reset.
  - Reset overrides any transfer in the same cycle. A word held at reset is discarded.
- in_ready is combinational from in_valid, mode, sel, ptr, out_valid and out_ready. There are no combinational paths from in_data to any output.
- Latency is 1 cycle: a word accepted at edge k is visible on out_data from edge k to k+1.
- Throughput is 1 word/cycle when out_ready is held high. Back-to-back transfers occur with no bubble.
- Simultaneous drain and load in one cycle is allowed. The new word replaces the old, and out_valid stays 1.
- While rst_n is low, in_ready is forced to 0.

## Test plan
- Reset, then fixed mode with N_CH = 4, DW = 1:
  - Stimulus: in_data = 4'b1010, all in_valid = 1, out_ready = 1, sel swept 0, 1, 2, 3.
  - Required: out_data = 0, 1, 0, 1 each one cycle later; out_ch = 0, 1, 2, 3.
- Round-robin fairness, N_CH = 4, DW = 8:
  - Stimulus: all valid, data = 8'hA0 + c, out_ready = 1.
  - Required: out_ch sequence 0, 1, 2, 3, 0, 1; out_data A0, A1, A2, A3, A0, A1; no idle cycle.
- Sparse requests and wrap-around:
  - Stimulus: only ch1 and ch3 valid, out_ready = 1.
  - Required: out_ch alternates 1, 3, 1, 3; in_ready[0] and in_ready[2] are never 1.
- Backpressure:
  - Stimulus: out_ready = 0 for 3 cycles with out_valid = 1 (word 8'hA2, ch2).
  - Required: out_data/out_ch hold at A2/2; all in_ready = 0; ptr unchanged. When out_ready rises, the next grant is ch3 in the same cycle.
- Mode switch and invalid select:
  - Stimulus: after RR grants of ch0 and ch1, set mode = 0, sel = 3, then sel = 5 (with N_CH = 6 to reach sel = 5 as valid, or an index ≥ N_CH to exercise the no-grant case).
  - Required: ch3 accepted. Returning to mode = 1 grants ch(ptr+1), with ptr = 3 → ch0.
  - Required: an out-of-range sel yields no transfer, and out_valid clears after drain.
- Reset mid-operation:
  - Stimulus: assert rst_n = 0 for 1 cycle while out_valid = 1 and out_ready = 0.
  - Required: next cycle out_valid = 0, out_data = 0, out_ch = 0. After release with all valid in RR mode, the first grant is ch0.
